// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : uart_pkg                                                   |
// | Description : Shared constants for the UART transmit-side blocks:       |
// |               arbiter state encoding, default timing parameters and a    |
// |               small helper used to size counters.                        |
// | Contents    : c_state_w, c_st_idle/c_st_wait_busy/c_st_wait_done/c_st_gap|
// |               c_busy_timeout_default, c_gap_cycles_default, max_int()    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package uart_pkg;

  localparam int c_state_w = 2;

  localparam logic [c_state_w-1:0] c_st_idle      = 2'd0;
  localparam logic [c_state_w-1:0] c_st_wait_busy = 2'd1;
  localparam logic [c_state_w-1:0] c_st_wait_done = 2'd2;
  localparam logic [c_state_w-1:0] c_st_gap       = 2'd3;

  localparam int c_busy_timeout_default = 16;
  localparam int c_gap_cycles_default   = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : uart_tx_arbiter_if                                         |
// | Description : Bundles the requester handshake and the transmitter pins   |
// |               around the transmit arbiter.                               |
// | Signals     : req/req_data/ack/grant_id  - requester side                |
// |               tx_data/tx_send/tx_busy     - transmitter side             |
// |               active/timeout_err          - status                       |
// | Modports    : master - the arbiter; slave - requesters + transmitter      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int c_id_w = $clog2(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   ack;
  logic [c_id_w-1:0]  grant_id;
  logic [7:0]         tx_data;
  logic               tx_send;
  logic               tx_busy;
  logic               active;
  logic               timeout_err;

  modport master (
    input  req, req_data, tx_busy,
    output ack, grant_id, tx_data, tx_send, active, timeout_err
  );

  modport slave (
    output req, req_data, tx_busy,
    input  ack, grant_id, tx_data, tx_send, active, timeout_err
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rr_pick                                                    |
// | Description : Combinational round-robin picker. Scans req starting one   |
// |               position after 'last', wrapping, and reports the first     |
// |               set bit as a one-hot vector and as an index.               |
// | Ports       : req    in  N_REQ  request vector                           |
// |               last   in  ID_W   previously granted index                 |
// |               win    out N_REQ  one-hot winner (all zero if no request)  |
// |               win_id out ID_W   winner index (equals last if no request) |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  wire logic [N_REQ-1:0] req,
  input  wire logic [ID_W-1:0]  last,
  output logic [N_REQ-1:0]      win,
  output logic [ID_W-1:0]       win_id
);

  // Walk offsets from farthest to nearest so the nearest set bit after
  // 'last' is the final assignment and therefore the winner.
  always_comb begin
    win    = '0;
    win_id = last;
    for (int k = N_REQ; k >= 1; k--) begin
      automatic int idx = (int'(last) + k) % N_REQ;
      if (req[idx]) begin
        win      = '0;
        win[idx] = 1'b1;
        win_id   = ID_W'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_tx_arbiter                                            |
// | Description : Round-robin arbiter sharing one UART transmitter between   |
// |               N_REQ byte producers. Grants one byte per frame, waits for |
// |               the transmitter busy cycle, then enforces an idle gap.     |
// | Ports       : clk     in  single clock                                   |
// |               reset   in  asynchronous active-low reset                  |
// |               bus     master modport of uart_tx_arbiter_if               |
// |                       (req, req_data, tx_busy in; ack, grant_id,         |
// |                        tx_data, tx_send, active, timeout_err out)        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = c_busy_timeout_default,
  parameter int GAP_CYCLES   = c_gap_cycles_default
) (
  input wire logic          clk,
  input wire logic          reset,
  uart_tx_arbiter_if.master bus
);

  localparam int c_id_w  = $clog2(N_REQ);
  localparam int c_cnt_w = $clog2(max_int(BUSY_TIMEOUT, GAP_CYCLES) + 1);

  localparam logic [c_cnt_w-1:0] c_busy_last = c_cnt_w'(BUSY_TIMEOUT - 1);
  // Never compared when GAP_CYCLES is 0 because GAP is then unreachable.
  localparam logic [c_cnt_w-1:0] c_gap_last =
    c_cnt_w'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  // Where a finished (or abandoned) frame goes: GAP, or straight to IDLE.
  localparam logic [c_state_w-1:0] c_st_after_frame =
    (GAP_CYCLES == 0) ? c_st_idle : c_st_gap;

  logic [c_state_w-1:0] r_state;
  logic [c_state_w-1:0] w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;

  logic [N_REQ-1:0]     w_win;
  logic [c_id_w-1:0]    w_win_id;
  logic                 w_grant;
  logic                 w_timeout;

  logic [N_REQ-1:0]     r_ack;
  logic [c_id_w-1:0]    r_grant_id;
  logic [7:0]           r_tx_data;
  logic                 r_tx_send;
  logic                 r_active;
  logic                 r_timeout_err;

  logic [N_REQ-1:0]     w_ack_nxt;
  logic [c_id_w-1:0]    w_grant_id_nxt;
  logic [7:0]           w_tx_data_nxt;
  logic                 w_tx_send_nxt;
  logic                 w_active_nxt;
  logic                 w_timeout_err_nxt;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (c_id_w)
  ) u_rr_pick (
    .req    (bus.req),
    .last   (r_grant_id),
    .win    (w_win),
    .win_id (w_win_id)
  );

  assign w_grant   = (r_state == c_st_idle) && !bus.tx_busy && (|bus.req);
  assign w_timeout = (r_state == c_st_wait_busy) && !bus.tx_busy &&
                     (r_cnt == c_busy_last);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_st_idle: begin
        if (w_grant) begin
          w_state_nxt = c_st_wait_busy;
          w_cnt_nxt   = '0;
        end
      end
      c_st_wait_busy: begin
        if (bus.tx_busy) begin
          w_state_nxt = c_st_wait_done;
        end else if (w_timeout) begin
          // The byte is dropped; no retry.
          w_state_nxt = c_st_after_frame;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      c_st_wait_done: begin
        if (!bus.tx_busy) begin
          w_state_nxt = c_st_after_frame;
          w_cnt_nxt   = '0;
        end
      end
      c_st_gap: begin
        if (r_cnt == c_gap_last) begin
          w_state_nxt = c_st_idle;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = c_st_idle;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output next-value logic; every output is registered below so that
  // ack, tx_send and tx_data leave the block on the same edge.
  always_comb begin
    w_ack_nxt         = '0;
    w_tx_send_nxt     = 1'b0;
    w_grant_id_nxt    = r_grant_id;
    w_tx_data_nxt     = r_tx_data;
    w_timeout_err_nxt = w_timeout;
    w_active_nxt      = (w_state_nxt != c_st_idle);
    if (w_grant) begin
      w_ack_nxt      = w_win;
      w_tx_send_nxt  = 1'b1;
      w_grant_id_nxt = w_win_id;
      w_tx_data_nxt  = bus.req_data[int'(w_win_id) * 8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack         <= '0;
      r_grant_id    <= c_id_w'(N_REQ - 1);
      r_tx_data     <= 8'h00;
      r_tx_send     <= 1'b0;
      r_active      <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_ack         <= w_ack_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_tx_data     <= w_tx_data_nxt;
      r_tx_send     <= w_tx_send_nxt;
      r_active      <= w_active_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  assign bus.ack         = r_ack;
  assign bus.grant_id    = r_grant_id;
  assign bus.tx_data     = r_tx_data;
  assign bus.tx_send     = r_tx_send;
  assign bus.active      = r_active;
  assign bus.timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_tx_arbiter                                         |
// | Description : Self-checking bench for uart_tx_arbiter. Two instances:    |
// |               inst 0 (BUSY_TIMEOUT=16, GAP_CYCLES=2) and inst 1          |
// |               (BUSY_TIMEOUT=4, GAP_CYCLES=0). A frame-level reference    |
// |               model predicts every output each cycle; directed scenarios |
// |               pin the model with hand-computed values, then random       |
// |               requesters and a random transmitter exercise both.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // Stimulus driven into the DUTs
  logic [3:0]  t_req  [2];
  logic [31:0] t_data [2];
  logic        t_busy [2];
  // DUT observations
  logic [3:0]  d_ack  [2];
  logic [1:0]  d_gid  [2];
  logic [7:0]  d_txd  [2];
  logic        d_send [2];
  logic        d_act  [2];
  logic        d_to   [2];
  // Model expectations
  logic [3:0]  e_ack  [2];
  logic [1:0]  e_gid  [2];
  logic [7:0]  e_txd  [2];
  logic        e_send [2];
  logic        e_act  [2];
  logic        e_to   [2];

  // Frame-level model: 0 free, 1 awaiting busy, 2 awaiting done, 3 in gap
  int m_phase [2];
  int m_last  [2];
  int m_send_cyc [2];
  int m_gap_end  [2];
  int cyc = 0;
  int m_w;

  // Transmitter / requester behaviour controls
  bit rand_en = 1'b0;
  bit norise     [2];
  bit force_busy [2];
  int tx_len     [2];
  int busy_left  [2];
  bit pend       [2];

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_arbiter_if #(.N_REQ(4)) bus0 ();
  uart_tx_arbiter_if #(.N_REQ(4)) bus1 ();

  uart_tx_arbiter #(.N_REQ(4), .BUSY_TIMEOUT(16), .GAP_CYCLES(2)) u_dut0 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus0.master)
  );

  uart_tx_arbiter #(.N_REQ(4), .BUSY_TIMEOUT(4), .GAP_CYCLES(0)) u_dut1 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus1.master)
  );

  assign bus0.req      = t_req[0];
  assign bus0.req_data = t_data[0];
  assign bus0.tx_busy  = t_busy[0];
  assign bus1.req      = t_req[1];
  assign bus1.req_data = t_data[1];
  assign bus1.tx_busy  = t_busy[1];

  assign d_ack[0]  = bus0.ack;
  assign d_gid[0]  = bus0.grant_id;
  assign d_txd[0]  = bus0.tx_data;
  assign d_send[0] = bus0.tx_send;
  assign d_act[0]  = bus0.active;
  assign d_to[0]   = bus0.timeout_err;
  assign d_ack[1]  = bus1.ack;
  assign d_gid[1]  = bus1.grant_id;
  assign d_txd[1]  = bus1.tx_data;
  assign d_send[1] = bus1.tx_send;
  assign d_act[1]  = bus1.active;
  assign d_to[1]   = bus1.timeout_err;

  function automatic int bt_of(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  // First requester after 'last' in circular order, or -1 if none.
  function automatic int rr_next(input logic [3:0] req, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (req[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic check(input int i, input string nm,
                       input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL inst%0d %s: got %0h expected %0h (t=%0t)", i, nm, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: advances once per rising edge using the inputs the
  // DUT samples on that edge, producing the outputs due after it.
  // ------------------------------------------------------------------
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_phase[i] = 0;
        m_last[i]  = 3;
        e_ack[i]   = 4'b0000;
        e_send[i]  = 1'b0;
        e_to[i]    = 1'b0;
        e_txd[i]   = 8'h00;
        e_gid[i]   = 2'd3;
        e_act[i]   = 1'b0;
      end else begin
        e_ack[i]  = 4'b0000;
        e_send[i] = 1'b0;
        e_to[i]   = 1'b0;
        case (m_phase[i])
          0: begin
            if (!t_busy[i] && t_req[i] != 4'b0000) begin
              m_w           = rr_next(t_req[i], m_last[i]);
              e_ack[i]      = 4'(1 << m_w);
              e_send[i]     = 1'b1;
              e_txd[i]      = t_data[i][8*m_w +: 8];
              e_gid[i]      = 2'(m_w);
              m_last[i]     = m_w;
              m_send_cyc[i] = cyc;
              m_phase[i]    = 1;
            end
          end
          1: begin
            if (t_busy[i]) begin
              m_phase[i] = 2;
            end else if (cyc - m_send_cyc[i] == bt_of(i)) begin
              e_to[i]      = 1'b1;
              m_gap_end[i] = cyc + gap_of(i);
              m_phase[i]   = (gap_of(i) == 0) ? 0 : 3;
            end
          end
          2: begin
            if (!t_busy[i]) begin
              m_gap_end[i] = cyc + gap_of(i);
              m_phase[i]   = (gap_of(i) == 0) ? 0 : 3;
            end
          end
          default: begin
            if (cyc == m_gap_end[i]) m_phase[i] = 0;
          end
        endcase
        e_act[i] = (m_phase[i] != 0);
      end
    end
  end

  // Compare process: every falling edge outside reset
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        check(i, "ack",         32'(d_ack[i]),  32'(e_ack[i]));
        check(i, "tx_send",     32'(d_send[i]), 32'(e_send[i]));
        check(i, "tx_data",     32'(d_txd[i]),  32'(e_txd[i]));
        check(i, "grant_id",    32'(d_gid[i]),  32'(e_gid[i]));
        check(i, "active",      32'(d_act[i]),  32'(e_act[i]));
        check(i, "timeout_err", 32'(d_to[i]),   32'(e_to[i]));
      end
    end
  end

  // Transmitter model and random requesters
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (pend[i]) begin
        pend[i]      = 1'b0;
        busy_left[i] = tx_len[i];
      end
      if (d_send[i] && (rand_en ? ($urandom_range(0, 7) != 0) : !norise[i])) begin
        pend[i] = 1'b1;
        if (rand_en) tx_len[i] = $urandom_range(1, 12);
      end
      if (rand_en && busy_left[i] == 0 && !pend[i] && $urandom_range(0, 49) == 0)
        busy_left[i] = $urandom_range(1, 3);
      if (force_busy[i]) begin
        t_busy[i] = 1'b1;
      end else if (busy_left[i] > 0) begin
        t_busy[i] = 1'b1;
        busy_left[i]--;
      end else begin
        t_busy[i] = 1'b0;
      end

      if (rand_en) begin
        for (int b = 0; b < 4; b++) begin
          if (d_ack[i][b]) begin
            if ($urandom_range(0, 1) == 0) t_data[i][8*b +: 8] = 8'($urandom);
            else t_req[i][b] = 1'b0;
          end else if (t_req[i][b]) begin
            if ($urandom_range(0, 63) == 0) t_req[i][b] = 1'b0;
          end else if ($urandom_range(0, 5) == 0) begin
            t_req[i][b]         = 1'b1;
            t_data[i][8*b +: 8] = 8'($urandom);
          end
        end
      end
    end
  end

  task automatic wait_ack(input int i, output int id);
    bit seen = 1'b0;
    id = -1;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge clk);
      if (d_ack[i] != 4'b0000) begin
        seen = 1'b1;
        for (int b = 0; b < 4; b++) if (d_ack[i][b]) id = b;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL inst%0d ack_wait: no ack within 80 cycles, required one", i);
    end
  endtask

  task automatic wait_idle(input int i);
    bit idle = 1'b0;
    for (int k = 0; k < 150 && !idle; k++) begin
      @(negedge clk);
      if (!d_act[i]) idle = 1'b1;
    end
    if (!idle) begin
      n_cmp++;
      n_bad++;
      $display("FAIL inst%0d idle_wait: active still 1 after 150 cycles, required 0", i);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int id;
    int n;
    int t_to;
    int order [6];
    order = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 2; i++) begin
      t_req[i] = 4'b0000; t_data[i] = 32'h0; t_busy[i] = 1'b0;
      norise[i] = 1'b0; force_busy[i] = 1'b0; tx_len[i] = 3;
      busy_left[i] = 0; pend[i] = 1'b0; m_phase[i] = 0; m_last[i] = 3;
      e_ack[i] = 4'b0; e_send[i] = 1'b0; e_to[i] = 1'b0;
      e_txd[i] = 8'h0; e_gid[i] = 2'd3; e_act[i] = 1'b0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    check(0, "rst_ack",      32'(d_ack[0]),  32'h0);
    check(0, "rst_tx_send",  32'(d_send[0]), 32'h0);
    check(0, "rst_tx_data",  32'(d_txd[0]),  32'h00);
    check(0, "rst_timeout",  32'(d_to[0]),   32'h0);
    check(0, "rst_active",   32'(d_act[0]),  32'h0);
    check(0, "rst_grant_id", 32'(d_gid[0]),  32'd3);
    rst_n = 1'b1;

    // Single request, busy 10 cycles
    @(negedge clk);
    tx_len[0] = 10;
    t_data[0] = 32'h008E_0000;
    t_req[0]  = 4'b0100;
    wait_ack(0, id);
    t_req[0] = 4'b0000;
    check(0, "single_ack",      32'(d_ack[0]),  32'h4);
    check(0, "single_tx_send",  32'(d_send[0]), 32'h1);
    check(0, "single_tx_data",  32'(d_txd[0]),  32'h8E);
    check(0, "single_grant_id", 32'(d_gid[0]),  32'd2);
    n = 1;
    for (int k = 0; k < 40 && d_act[0]; k++) begin
      @(negedge clk);
      if (d_act[0]) n++;
    end
    check(0, "single_active_len", 32'(n), 32'd14);

    // GAP_CYCLES=0 instance: back-to-back grants
    tx_len[1] = 3;
    t_data[1] = 32'h0000_B2A1;
    t_req[1]  = 4'b0011;
    wait_ack(1, id);
    check(1, "gap0_first_id", 32'(id), 32'd0);
    t_req[1] = 4'b0010;
    n = 0;
    id = -1;
    for (int k = 0; k < 40 && id < 0; k++) begin
      @(negedge clk);
      n++;
      if (d_ack[1] != 4'b0) id = (d_ack[1] == 4'b0010) ? 1 : 9;
    end
    t_req[1] = 4'b0000;
    check(1, "gap0_second_id", 32'(id), 32'd1);
    check(1, "gap0_spacing",   32'(n),  32'd6);
    wait_idle(1);

    // Round-robin fairness from reset
    do_reset();
    tx_len[0] = 3;
    t_data[0] = 32'hA3B2_C1D0;
    t_req[0]  = 4'b1111;
    for (int j = 0; j < 6; j++) begin
      wait_ack(0, id);
      check(0, $sformatf("rr_order%0d", j), 32'(id), 32'(order[j]));
    end
    t_req[0] = 4'b0000;
    wait_idle(0);

    // Busy-rise timeout, then next in rotation
    norise[0] = 1'b1;
    t_req[0]  = 4'b1111;
    wait_ack(0, id);
    check(0, "to_first_id", 32'(id), 32'd2);
    t_req[0] = 4'b1011;
    n = 0;
    t_to = -1;
    id = -1;
    for (int k = 0; k < 60 && id < 0; k++) begin
      @(negedge clk);
      n++;
      if (d_to[0] && t_to < 0) t_to = n;
      if (d_ack[0] != 4'b0) for (int b = 0; b < 4; b++) if (d_ack[0][b]) id = b;
    end
    t_req[0] = 4'b0000;
    check(0, "to_delay",   32'(t_to), 32'd16);
    check(0, "to_next_id", 32'(id),   32'd3);
    check(0, "to_spacing", 32'(n),    32'd19);
    wait_idle(0);
    norise[0] = 1'b0;
    tx_len[0] = 10;

    // Busy high while idle blocks the grant
    force_busy[0] = 1'b1;
    t_busy[0]     = 1'b1;
    t_data[0]     = 32'h0000_005A;
    t_req[0]      = 4'b0001;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (d_ack[0] != 4'b0) n++;
    end
    check(0, "busy_idle_no_grant", 32'(n), 32'd0);
    force_busy[0] = 1'b0;
    t_busy[0]     = 1'b0;
    @(negedge clk);
    check(0, "busy_idle_grant", 32'(d_ack[0]), 32'h1);
    t_req[0] = 4'b0000;
    wait_idle(0);

    // Asynchronous reset during WAIT_DONE
    t_data[0] = 32'h0000_0033;
    t_req[0]  = 4'b0001;
    wait_ack(0, id);
    t_req[0] = 4'b0000;
    repeat (3) @(negedge clk);
    check(0, "mid_active_before", 32'(d_act[0]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check(0, "arst_active",   32'(d_act[0]),  32'h0);
    check(0, "arst_ack",      32'(d_ack[0]),  32'h0);
    check(0, "arst_tx_send",  32'(d_send[0]), 32'h0);
    check(0, "arst_tx_data",  32'(d_txd[0]),  32'h00);
    check(0, "arst_grant_id", 32'(d_gid[0]),  32'd3);
    t_data[0] = 32'h7700_0011;
    t_req[0]  = 4'b1001;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ack(0, id);
    t_req[0] = 4'b0000;
    check(0, "post_rst_id",      32'(id),       32'd0);
    check(0, "post_rst_tx_data", 32'(d_txd[0]), 32'h11);
    wait_idle(0);

    // Randomised traffic on both instances
    rand_en = 1'b1;
    repeat (3000) @(negedge clk);
    rand_en = 1'b0;
    @(negedge clk);
    t_req[0] = 4'b0000;
    t_req[1] = 4'b0000;
    wait_idle(0);
    wait_idle(1);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1000000");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_transmitter` among `N_REQ` byte producers (e.g. echo path, status reporter, debug dump). It accepts one byte per grant and drives the transmitter's `data`/`send` pins. It tracks the transmitter's `busy` output to know when the line is free, and enforces a minimum inter-frame gap. It sits between the requesters and the transmitter, replacing direct `send` triggering from single pulsers.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `BUSY_TIMEOUT`, 16: cycles to wait for `tx_busy` to rise after `tx_send` before declaring a fault, ≥2.
- `GAP_CYCLES`, 2: idle cycles enforced after `tx_busy` falls before the next grant, ≥0.
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester request; level, held until `ack`.
- `req_data`  in  8*N_REQ  byte of requester i on bits [8i+7:8i].
- `ack`  out  N_REQ  one-cycle pulse; byte of that requester captured.
- `grant_id`  out  clog2(N_REQ)  index of last granted requester.
- `tx_data`  out  8  to transmitter `data`; held stable from grant until return to IDLE.
- `tx_send`  out  1  to transmitter `send`; one-cycle pulse.
- `tx_busy`  in  1  from transmitter `busy`.
- `active`  out  1  high in every state except IDLE.
- `timeout_err`  out  1  one-cycle pulse on busy-rise timeout.

## Operation
- States: IDLE, WAIT_BUSY, WAIT_DONE, GAP.
- **IDLE:** grants only if `tx_busy`=0 and `req`≠0.
  - Winner is the first set bit scanning from (`grant_id`+1) mod N_REQ upward, wrapping.
  - At that edge: `tx_data` ← winner's byte, `ack[winner]`=1, `tx_send`=1, `grant_id` ← winner, counter ← 0, go to WAIT_BUSY.
- **WAIT_BUSY:**
  - `tx_busy`=1: go to WAIT_DONE.
  - Otherwise the counter increments. When the counter reaches BUSY_TIMEOUT-1, pulse `timeout_err` and go to GAP. The byte is considered lost and is not retried.
- **WAIT_DONE:** on `tx_busy`=0, counter ← 0 and go to GAP.
- **GAP:** counter increments. Go to IDLE when counter = GAP_CYCLES-1. With GAP_CYCLES=0, GAP is skipped: WAIT_DONE and the timeout path go straight to IDLE.
- Requester contract:
  - Drop `req` in the cycle after `ack`.
  - A request still high after `ack` is arbitrated again as a new byte.
  - `req_data` must be stable while `req` is high.
- `req` bits that drop before `ack` are simply not granted; there is no latching of requests.
- Simultaneous requests are granted in round-robin order. Each requester waits at most N_REQ-1 grants.
- `tx_busy` rising in IDLE or GAP is ignored, except that IDLE will not grant while it is high.

## Timing
- All outputs are registered.
- Reset values:
  - `ack`=0, `tx_send`=0, `tx_data`=8'h00, `timeout_err`=0, `active`=0.
  - `grant_id`=N_REQ-1, so requester 0 has top priority after reset.
  - State = IDLE, counter = 0.
- Grant latency: `req` sampled high at edge k → `ack`, `tx_send` and the new `tx_data` all valid after edge k. They are coincident, so the transmitter samples data and send together.
- `tx_send` and `ack` are high for exactly one cycle per grant.
- Minimum grant-to-grant spacing is 1 (send) + busy duration + 1 (done detect) + GAP_CYCLES cycles.
- Timeout: `timeout_err` is asserted after the edge where the counter = BUSY_TIMEOUT-1, i.e. BUSY_TIMEOUT cycles after `tx_send`.
- Reset asserted mid-operation:
  - Outputs clear immediately (asynchronous) and the state returns to IDLE.
  - The arbiter does not reset the transmitter; system reset does.
- Counter width is clog2(max(BUSY_TIMEOUT, GAP_CYCLES)+1).

## Structure
- A shared package `uart_pkg` holds:
  - the state encoding constants (IDLE=0, WAIT_BUSY=1, WAIT_DONE=2, GAP=3);
  - the default BUSY_TIMEOUT and GAP_CYCLES.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req`, `last` pointer.
  - Outputs: one-hot `win` and `win_id`.
  - It is parameterised by N_REQ and is reusable for the future receive-side router.
- The top holds the FSM, counter, data mux and output registers.

## Test plan
- **Single request:** N_REQ=4. req=4'b0100, req_data[23:16]=8'h8E. The transmitter model raises busy 1 cycle after send and holds it 10 cycles. Required: `ack`=4'b0100 and `tx_send`=1 in the same cycle, `tx_data`=8'h8E, `grant_id`=2, `active` returns to 0 after 10+1+2 further cycles.
- **Round-robin fairness:** req=4'b1111 held, with each requester re-raising after `ack`. Required grant order after reset: 0,1,2,3,0,1; each ack is one cycle.
- **Timeout:** busy held low after send, BUSY_TIMEOUT=16. Required: `timeout_err` pulses once 16 cycles after `tx_send`; no second `tx_send` until GAP completes; the next grant goes to the next requester in rotation.
- **Busy at idle:** `tx_busy` forced high while req=4'b0001. Required: no grant until busy falls; grant occurs on the first edge with busy=0.
- **Reset mid-frame:** `reset` driven low during WAIT_DONE. Required: `active`, `ack`, `tx_send` and `tx_data` cleared asynchronously, `grant_id`=3; after release, req=4'b1001 grants requester 0 first.
- **GAP_CYCLES=0:** back-to-back requests. Required: the next `tx_send` comes one cycle after busy is sampled low.
